// File: rtl/ysyx_24100006_mem_arbiter.sv
// Two-master (IFU / LSU) to one-slave memory bus arbiter, one transaction in flight.
// Optional response watchdog enabled with `define ARB_TIMEOUT_EN.
module ysyx_24100006_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_write,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_mask,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_rsp_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [2:0]        bus_mask,
    input  logic              bus_rsp_valid,
    output logic              bus_rsp_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rsp_err,
    input  logic              flush_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        IF_REQ,
        IF_RSP,
        LS_REQ,
        LS_RSP
    } state_e;

    localparam logic [2:0] MASK_WORD = 3'b010;

    state_e            state_q;
    logic              drop_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        mask_q;

    logic in_idle;
    logic grant_ls;
    logic grant_if;
    logic if_phase;
    logic drop_now;
    logic req_hs;
    logic owner_ready;
    logic rsp_done;
    logic to_q;
    logic to_hit;

    assign in_idle  = (state_q == IDLE);
    assign grant_ls = in_idle && ls_req_valid;
    assign grant_if = in_idle && !ls_req_valid && if_req_valid && !flush_i;
    assign if_phase = (state_q == IF_REQ) || (state_q == IF_RSP);
    // A flush arriving together with the response must already hide it.
    assign drop_now = drop_q || (if_phase && flush_i);
    assign req_hs   = req_valid_q && bus_req_ready;

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign bus_req_valid = req_valid_q;
    assign bus_addr      = addr_q;
    assign bus_write     = write_q;
    assign bus_wdata     = wdata_q;
    assign bus_mask      = mask_q;
    assign busy_o        = !in_idle;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    assign to_hit = !in_idle && !to_q &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current REQ/RSP state; restarts on each state entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (in_idle || req_hs) begin
            cnt_q <= '0;
        end else if (!to_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Watchdog fired: owner sees a synthetic error until it takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q <= 1'b0;
        end else if (in_idle || rsp_done) begin
            to_q <= 1'b0;
        end else if (to_hit) begin
            to_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign to_q           = 1'b0;
    assign to_hit         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign owner_ready = (state_q == IF_RSP) ? if_rsp_ready : ls_rsp_ready;

    // Response phase ends on a bus handshake, or on delivery of a timeout error.
    always_comb begin
        rsp_done = 1'b0;
        if ((state_q == IF_RSP) || (state_q == LS_RSP)) begin
            if (to_q) begin
                rsp_done = owner_ready || ((state_q == IF_RSP) && drop_now);
            end else begin
                rsp_done = bus_rsp_valid && bus_rsp_ready;
            end
        end
    end

    // Route the downstream response to the owner, or swallow it.
    always_comb begin
        if_rsp_valid  = 1'b0;
        if_rdata      = '0;
        if_rsp_err    = 1'b0;
        ls_rsp_valid  = 1'b0;
        ls_rdata      = '0;
        ls_rsp_err    = 1'b0;
        bus_rsp_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus_rsp_ready = 1'b1;
            end
            IF_RSP: begin
                if (to_q) begin
                    if_rsp_valid  = !drop_now;
                    if_rsp_err    = !drop_now;
                    bus_rsp_ready = 1'b1;
                end else begin
                    if_rsp_valid  = bus_rsp_valid && !drop_now;
                    if_rdata      = bus_rdata;
                    if_rsp_err    = bus_rsp_err && !drop_now;
                    bus_rsp_ready = drop_now ? 1'b1 : if_rsp_ready;
                end
            end
            LS_RSP: begin
                if (to_q) begin
                    ls_rsp_valid  = 1'b1;
                    ls_rsp_err    = 1'b1;
                    bus_rsp_ready = 1'b1;
                end else begin
                    ls_rsp_valid  = bus_rsp_valid;
                    ls_rdata      = bus_rdata;
                    ls_rsp_err    = bus_rsp_err;
                    bus_rsp_ready = ls_rsp_ready;
                end
            end
            default: begin
                bus_rsp_ready = 1'b0;
            end
        endcase
    end

    // Arbitration FSM with registered bus request fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_ls) begin
                        addr_q      <= ls_addr;
                        write_q     <= ls_write;
                        wdata_q     <= ls_wdata;
                        mask_q      <= ls_mask;
                        req_valid_q <= 1'b1;
                        state_q     <= LS_REQ;
                    end else if (grant_if) begin
                        addr_q      <= if_addr;
                        write_q     <= 1'b0;
                        wdata_q     <= '0;
                        mask_q      <= MASK_WORD;
                        req_valid_q <= 1'b1;
                        state_q     <= IF_REQ;
                    end
                end
                IF_REQ, LS_REQ: begin
                    if ((state_q == IF_REQ) && flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (to_hit || bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (state_q == IF_REQ) ? IF_RSP : LS_RSP;
                    end
                end
                IF_RSP, LS_RSP: begin
                    if ((state_q == IF_RSP) && flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (rsp_done) begin
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    drop_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Scoreboard bench for ysyx_24100006_mem_arbiter (default build).
// Expected bus requests and master responses are queued at stimulus time.
module tb_ysyx_24100006_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid, if_rsp_ready;
    logic [31:0] if_rdata;
    logic        if_rsp_err;
    logic        ls_req_valid, ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_write;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_mask;
    logic        ls_rsp_valid, ls_rsp_ready;
    logic [31:0] ls_rdata;
    logic        ls_rsp_err;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_mask;
    logic        bus_rsp_valid, bus_rsp_ready;
    logic [31:0] bus_rdata;
    logic        bus_rsp_err;
    logic        flush_i, busy_o;

    int n_chk = 0;
    int n_err = 0;

    logic [67:0] bus_q[$];
    logic [32:0] if_q[$];
    logic [32:0] ls_q[$];

    always #5 clk = ~clk;

    ysyx_24100006_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
        .if_rsp_ready(if_rsp_ready), .if_rdata(if_rdata),
        .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_addr(ls_addr), .ls_write(ls_write), .ls_wdata(ls_wdata),
        .ls_mask(ls_mask), .ls_rsp_valid(ls_rsp_valid),
        .ls_rsp_ready(ls_rsp_ready), .ls_rdata(ls_rdata),
        .ls_rsp_err(ls_rsp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_mask(bus_mask),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
        .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [67:0] act,
                       input logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare every handshake against the queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus_req_valid && bus_req_ready) begin
                chk("bus_expected", 68'(bus_q.size() != 0), 68'd1);
                if (bus_q.size() != 0)
                    chk("bus_req", {bus_write, bus_addr, bus_wdata, bus_mask},
                        bus_q.pop_front());
            end
            if (if_rsp_valid && if_rsp_ready) begin
                chk("if_expected", 68'(if_q.size() != 0), 68'd1);
                if (if_q.size() != 0)
                    chk("if_rsp", 68'({if_rsp_err, if_rdata}),
                        68'(if_q.pop_front()));
            end
            if (ls_rsp_valid && ls_rsp_ready) begin
                chk("ls_expected", 68'(ls_q.size() != 0), 68'd1);
                if (ls_q.size() != 0)
                    chk("ls_rsp", 68'({ls_rsp_err, ls_rdata}),
                        68'(ls_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic grant_if(input logic [31:0] a);
        if_req_valid = 1'b1;
        if_addr      = a;
        bus_q.push_back({1'b0, a, 32'h0, 3'b010});
        smp();
        chk("if_grant", 68'(if_req_ready), 68'd1);
        step();
        if_req_valid = 1'b0;
    endtask

    task automatic grant_ls(input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input logic [2:0] m);
        ls_req_valid = 1'b1;
        ls_addr      = a;
        ls_write     = w;
        ls_wdata     = wd;
        ls_mask      = m;
        bus_q.push_back({w, a, wd, m});
        smp();
        chk("ls_grant", 68'(ls_req_ready), 68'd1);
        step();
        ls_req_valid = 1'b0;
    endtask

    // Bus slave: accept the pending request, then return one response.
    task automatic serve(input logic [31:0] d, input logic e);
        int n;
        n = 0;
        bus_req_ready = 1'b1;
        smp();
        while (!bus_req_valid && n < 20) begin
            step();
            smp();
            n++;
        end
        chk("req_wait", 68'(n < 20), 68'd1);
        step();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rdata     = d;
        bus_rsp_err   = e;
        n = 0;
        smp();
        while (!bus_rsp_ready && n < 20) begin
            step();
            smp();
            n++;
        end
        chk("rsp_wait", 68'(n < 20), 68'd1);
        step();
        bus_rsp_valid = 1'b0;
        bus_rdata     = '0;
        bus_rsp_err   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        if_req_valid = 0; if_addr = 0; if_rsp_ready = 1;
        ls_req_valid = 0; ls_addr = 0; ls_write = 0; ls_wdata = 0;
        ls_mask = 0; ls_rsp_ready = 1;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
        bus_rsp_err = 0; flush_i = 0;
        step();
        step();
        smp();
        chk("rst_busy", 68'(busy_o), 68'd0);
        chk("rst_req_valid", 68'(bus_req_valid), 68'd0);
        chk("rst_rsp_ready", 68'(bus_rsp_ready), 68'd1);
        chk("rst_fields", {bus_write, bus_addr, bus_wdata, bus_mask}, 68'd0);
        step();
        reset = 1'b1;
        step();

        // Single fetch with exact cycle timing.
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0000;
        bus_q.push_back({1'b0, 32'h8000_0000, 32'h0, 3'b010});
        if_q.push_back({1'b0, 32'h0000_0413});
        smp();
        chk("t1_if_ready", 68'(if_req_ready), 68'd1);
        chk("t1_ls_ready", 68'(ls_req_ready), 68'd0);
        step();
        if_req_valid  = 1'b0;
        bus_req_ready = 1'b1;
        smp();
        chk("t1_req_valid", 68'(bus_req_valid), 68'd1);
        step();
        bus_req_ready = 1'b0;
        smp();
        chk("t1_busy", 68'(busy_o), 68'd1);
        chk("t1_no_rsp", 68'(if_rsp_valid), 68'd0);
        chk("t1_req_drop", 68'(bus_req_valid), 68'd0);
        step();
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h0000_0413;
        smp();
        chk("t1_rsp_valid", 68'(if_rsp_valid), 68'd1);
        chk("t1_bus_ready", 68'(bus_rsp_ready), 68'd1);
        step();
        bus_rsp_valid = 1'b0;
        smp();
        chk("t1_idle", 68'(busy_o), 68'd0);
        step();

        // Simultaneous requests: LSU store first, IFU right after.
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0004;
        ls_req_valid = 1'b1;
        ls_addr      = 32'hA000_0000;
        ls_write     = 1'b1;
        ls_wdata     = 32'hDEAD_BEEF;
        ls_mask      = 3'b010;
        bus_q.push_back({1'b1, 32'hA000_0000, 32'hDEAD_BEEF, 3'b010});
        ls_q.push_back({1'b0, 32'h0});
        smp();
        chk("t2_ls_first", 68'(ls_req_ready), 68'd1);
        chk("t2_if_wait", 68'(if_req_ready), 68'd0);
        step();
        ls_req_valid = 1'b0;
        ls_write     = 1'b0;
        ls_wdata     = 32'h0;
        serve(32'h0, 1'b0);
        bus_q.push_back({1'b0, 32'h8000_0004, 32'h0, 3'b010});
        if_q.push_back({1'b0, 32'h0010_0093});
        smp();
        chk("t2_if_next", 68'(if_req_ready), 68'd1);
        step();
        if_req_valid = 1'b0;
        serve(32'h0010_0093, 1'b0);

        // Flush during IF_RSP drops the late fetch response.
        grant_if(32'h8000_0008);
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        flush_i       = 1'b1;
        if_rsp_ready  = 1'b0;
        smp();
        chk("t3_no_rsp", 68'(if_rsp_valid), 68'd0);
        step();
        flush_i       = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h1234_5678;
        smp();
        chk("t3_dropped", 68'(if_rsp_valid), 68'd0);
        chk("t3_swallow", 68'(bus_rsp_ready), 68'd1);
        step();
        bus_rsp_valid = 1'b0;
        if_rsp_ready  = 1'b1;
        smp();
        chk("t3_idle", 68'(busy_o), 68'd0);
        step();
        if_q.push_back({1'b0, 32'hCAFE_0001});
        grant_if(32'h8000_000C);
        serve(32'hCAFE_0001, 1'b0);

        // Flush in the same cycle as the response.
        grant_if(32'h8000_0010);
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        flush_i       = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hFFFF_0000;
        smp();
        chk("t3b_dropped", 68'(if_rsp_valid), 68'd0);
        chk("t3b_swallow", 68'(bus_rsp_ready), 68'd1);
        step();
        flush_i       = 1'b0;
        bus_rsp_valid = 1'b0;
        smp();
        chk("t3b_idle", 68'(busy_o), 68'd0);
        step();

        // Flush does not affect an LSU load.
        grant_ls(32'h0000_0040, 1'b0, 32'h0, 3'b010);
        ls_q.push_back({1'b0, 32'h55AA_55AA});
        flush_i = 1'b1;
        serve(32'h55AA_55AA, 1'b0);
        flush_i = 1'b0;

        // Backpressure on the LSU response path.
        grant_ls(32'h0000_0080, 1'b0, 32'h0, 3'b001);
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        ls_rsp_ready  = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t5_bus_stall", 68'(bus_rsp_ready), 68'd0);
            chk("t5_ls_valid", 68'(ls_rsp_valid), 68'd1);
            chk("t5_ls_data", 68'(ls_rdata), 68'h0BAD_F00D);
            step();
        end
        ls_q.push_back({1'b0, 32'h0BAD_F00D});
        ls_rsp_ready = 1'b1;
        smp();
        chk("t5_release", 68'(bus_rsp_ready), 68'd1);
        step();
        bus_rsp_valid = 1'b0;
        smp();
        chk("t5_idle", 68'(busy_o), 68'd0);
        step();

        // Error response passes through to the LSU.
        grant_ls(32'h0000_0100, 1'b1, 32'h1122_3344, 3'b000);
        ls_q.push_back({1'b1, 32'h0});
        serve(32'h0, 1'b1);

        // Stray response in IDLE is accepted and ignored.
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h7777_7777;
        smp();
        chk("t7_ready", 68'(bus_rsp_ready), 68'd1);
        chk("t7_if", 68'(if_rsp_valid), 68'd0);
        chk("t7_ls", 68'(ls_rsp_valid), 68'd0);
        step();
        bus_rsp_valid = 1'b0;
        smp();
        chk("t7_idle", 68'(busy_o), 68'd0);
        step();

        // Flush blocks an IFU grant in IDLE.
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0018;
        flush_i      = 1'b1;
        smp();
        chk("t8_blocked", 68'(if_req_ready), 68'd0);
        step();
        if_req_valid = 1'b0;
        flush_i      = 1'b0;
        smp();
        chk("t8_idle", 68'(busy_o), 68'd0);
        step();

        // Request fields stay stable while stalled, then reset aborts.
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0020;
        step();
        if_req_valid = 1'b0;
        if_addr      = 32'h0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t9_hold_valid", 68'(bus_req_valid), 68'd1);
            chk("t9_hold_addr", 68'(bus_addr), 68'h8000_0020);
            step();
        end
        reset = 1'b0;
        #1;
        chk("t9_rst_busy", 68'(busy_o), 68'd0);
        chk("t9_rst_valid", 68'(bus_req_valid), 68'd0);
        chk("t9_rst_addr", 68'(bus_addr), 68'd0);
        step();
        reset = 1'b1;
        step();

        chk("bus_q_empty", 68'(bus_q.size()), 68'd0);
        chk("if_q_empty", 68'(if_q.size()), 68'd0);
        chk("ls_q_empty", 68'(ls_q.size()), 68'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_mem_arbiter.md
Name: ysyx_24100006_mem_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single memory bus between the instruction fetch unit (IFU) and the load/store unit (MEMU/LSU).
- Sits between the IFU and the MEMU-side of the EXE/MEM pipeline register, and the downstream bus bridge.
- Holds one outstanding transaction at a time.
- Drops fetch responses invalidated by a pipeline flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, response watchdog limit; used only with the optional feature

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- if_req_valid  input  1  IFU request valid
- if_req_ready  output  1  IFU request accepted
- if_addr  input  ADDR_W  IFU fetch address
- if_rsp_valid  output  1  IFU response valid
- if_rsp_ready  input  1  IFU response accepted
- if_rdata  output  DATA_W  fetch data
- if_rsp_err  output  1  fetch error
- ls_req_valid  input  1  LSU request valid
- ls_req_ready  output  1  LSU request accepted
- ls_addr  input  ADDR_W  LSU address
- ls_write  input  1  1=store, 0=load
- ls_wdata  input  DATA_W  store data
- ls_mask  input  3  access size/mask code, Mem_Mask encoding
- ls_rsp_valid  output  1  LSU response valid
- ls_rsp_ready  input  1  LSU response accepted
- ls_rdata  output  DATA_W  load data
- ls_rsp_err  output  1  access error
- bus_req_valid  output  1  downstream request valid
- bus_req_ready  input  1  downstream accepts request
- bus_addr, bus_write, bus_wdata, bus_mask  output  ADDR_W/1/DATA_W/3  registered request fields
- bus_rsp_valid  input  1  downstream response valid
- bus_rsp_ready  output  1  arbiter accepts response
- bus_rdata  input  DATA_W  response data
- bus_rsp_err  input  1  response error
- flush_i  input  1  pipeline flush (redirect/exception)
- busy_o  output  1  state != IDLE

Behaviour:
- States: IDLE, IF_REQ, IF_RSP, LS_REQ, LS_RSP.
- Reset values (async, reset low):
  - state=IDLE, drop flag=0, all bus_* request fields=0
  - all *_ready outputs and *_valid outputs = 0, except bus_rsp_ready=1 in IDLE
- IDLE grant:
  - ls_req_valid has fixed priority.
  - Else if_req_valid && !flush_i.
  - The granted master's *_req_ready=1 combinationally in this cycle only; its fields are captured into the bus_* registers; next state is X_REQ.
  - IFU write fields are captured as write=0, wdata=0, mask=3'b010 (word).
- X_REQ:
  - bus_req_valid=1.
  - On bus_req_ready, next state is X_RSP.
  - Fields are stable while bus_req_valid=1.
- X_RSP:
  - The owner's rsp_valid equals bus_rsp_valid; rdata/err pass through combinationally; bus_rsp_ready equals the owner's rsp_ready.
  - On the bus_rsp handshake, next state is IDLE.
- Minimum latency: accept at cycle 0, bus_req_valid at cycle 1, response forwarded in the same cycle bus_rsp_valid arrives.
- Back-to-back: a new grant is possible in the IDLE cycle following the response handshake (1 idle cycle between transactions).
- Flush:
  - flush_i in IF_REQ or IF_RSP sets drop=1.
  - While drop=1: if_rsp_valid=0, bus_rsp_ready=1, and the response is swallowed.
  - drop clears on return to IDLE.
  - flush_i in the same cycle as the response handshake in IF_RSP suppresses that response.
  - LS transactions are never dropped; stores must complete.
- In IDLE, bus_rsp_valid is accepted and ignored (stray responses).
- Reset asserted mid-transaction: immediate return to IDLE; the downstream bus bridge shares the reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in X_REQ/X_RSP and clears on state entry.
  - On reaching TIMEOUT_CYCLES, the owner gets rsp_valid=1, rdata=0, rsp_err=1 (held until its rsp_ready, or discarded if drop=1).
  - bus_req_valid deasserts and the state returns to IDLE.
  - A late response is swallowed in IDLE.
- When undefined: no counter; the arbiter waits indefinitely.

Test Plan:
- Single IFU fetch at 0x80000000, bus ready at cycle 1, response 0x00000413 at cycle 3 -> if_req_ready at cycle 0; bus_addr=0x80000000, write=0; if_rdata=0x00000413 at cycle 3; state IDLE at cycle 4.
- IFU and LSU valid in the same IDLE cycle, LSU store 0xDEADBEEF to 0xA0000000 mask 3'b010 -> LSU granted first with bus_write=1; IFU granted in the IDLE cycle after LSU response.
- flush_i pulsed during IF_RSP, bus returns 0x12345678 -> if_rsp_valid stays 0; bus_rsp_ready=1; next grant proceeds normally.
- flush_i during an LSU load -> ls_rsp_valid delivered with data intact.
- Backpressure: ls_rsp_ready=0 for 5 cycles with bus_rsp_valid=1 -> bus_rsp_ready=0; ls_rdata stable; completes when ls_rsp_ready=1.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, bus never responds -> at cycle 8 of the transaction, if_rsp_err=1 and if_rdata=0; state returns to IDLE; a later stray bus_rsp_valid is ignored.
